// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C master
// between N_REQ requesters. It latches the winner's address/data, issues one
// start pulse, follows the master's busy/valid handshake and reports
// completion, read data and timeout back to the granted requester.
module i2c_master_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rstn,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*8-1:0] i_addr,
    input  logic [N_REQ*8-1:0] i_wdata,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_done,
    output logic               o_err,
    output logic [7:0]         o_rdata,
    output logic               o_rvalid,
    output logic [7:0]         o_m_address,
    output logic [7:0]         o_m_write_data,
    output logic               o_m_req_trans,
    input  logic               i_m_busy,
    input  logic [7:0]         i_m_read_data,
    input  logic               i_m_valid_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(N_REQ);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic [CW-1:0]   cnt;
    logic            read_seen;

    logic [PW-1:0]   pick;
    logic            pick_found;
    logic [7:0]      sel_addr;
    logic [7:0]      sel_wdata;

    // Round-robin pick: the lowest requester at or above ptr wins, otherwise
    // wrap around to the lowest requester overall.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                pick       = PW'(k);
                pick_found = 1'b1;
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k] && (PW'(k) >= ptr)) begin
                pick = PW'(k);
            end
        end
    end

    // Route the picked requester's address and write byte toward the latch.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == PW'(k)) begin
                sel_addr  = i_addr[k*8 +: 8];
                sel_wdata = i_wdata[k*8 +: 8];
            end
        end
    end

    // Transaction sequencer: grant, start pulse, handshake tracking, completion.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            state          <= IDLE;
            ptr            <= '0;
            win_idx        <= '0;
            cnt            <= '0;
            read_seen      <= 1'b0;
            o_gnt          <= '0;
            o_done         <= '0;
            o_err          <= 1'b0;
            o_rdata        <= '0;
            o_rvalid       <= 1'b0;
            o_m_address    <= '0;
            o_m_write_data <= '0;
            o_m_req_trans  <= 1'b0;
        end else begin
            o_m_req_trans <= 1'b0;
            o_done        <= '0;
            o_err         <= 1'b0;
            o_rvalid      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found && !i_m_busy) begin
                        win_idx        <= pick;
                        o_gnt          <= N_REQ'(1) << pick;
                        o_m_address    <= sel_addr;
                        o_m_write_data <= sel_wdata;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_m_req_trans <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT_START;
                end
                WAIT_START: begin
                    if (i_m_busy) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else if (cnt == CNT_MAX) begin
                        o_done <= o_gnt;
                        o_err  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (i_m_valid_out) begin
                        o_rdata   <= i_m_read_data;
                        read_seen <= 1'b1;
                    end
                    if (!i_m_busy) begin
                        o_done   <= o_gnt;
                        o_rvalid <= o_m_address[0] && (read_seen || i_m_valid_out);
                        state    <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        o_done <= o_gnt;
                        o_err  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_gnt     <= '0;
                    ptr       <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    read_seen <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Testbench for i2c_master_arbiter: a behavioural master model, a driver that
// predicts each transaction into a scoreboard queue, and a monitor that checks
// every start pulse and completion against the queue.
module tb_i2c_master_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] i_req;
    logic [N*8-1:0] i_addr;
    logic [N*8-1:0] i_wdata;
    logic [N-1:0] o_gnt;
    logic [N-1:0] o_done;
    logic         o_err;
    logic [7:0]   o_rdata;
    logic         o_rvalid;
    logic [7:0]   o_m_address;
    logic [7:0]   o_m_write_data;
    logic         o_m_req_trans;
    logic         m_busy;
    logic [7:0]   m_rdata;
    logic         m_valid;

    i2c_master_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_sys_clk      (clk),
        .i_sys_rstn     (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_gnt          (o_gnt),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_rdata        (o_rdata),
        .o_rvalid       (o_rvalid),
        .o_m_address    (o_m_address),
        .o_m_write_data (o_m_write_data),
        .o_m_req_trans  (o_m_req_trans),
        .i_m_busy       (m_busy),
        .i_m_read_data  (m_rdata),
        .i_m_valid_out  (m_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         w;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       err;
        logic       rvalid;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   served[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_issue = 0;
    bit   front_issued = 1'b0;

    logic [N-1:0] req_m;
    logic [7:0]   addr_m[N];
    logic [7:0]   wd_m[N];
    int           ptr_m = 0;
    int           cur_w = 0;
    logic [7:0]   last_rdata = 8'h00;
    bit           manual = 1'b0;

    int           m_mode = 0;
    int           m_blen = 1;
    int           m_vat = 0;
    logic [7:0]   m_rbyte = 8'h00;

    // Compare one value and report a failure line if it differs.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive the requester-side inputs from the model arrays.
    task automatic apply_stimulus();
        i_req = req_m;
        for (int k = 0; k < N; k++) begin
            i_addr[k*8 +: 8]  = addr_m[k];
            i_wdata[k*8 +: 8] = wd_m[k];
        end
    endtask

    // Reference round robin: scan requesters in rotated order starting at p.
    function automatic int rr_winner(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Predict the next transaction, configure the master model, queue the expectation.
    // mode 0: normal, mode 1: master never goes busy, mode 2: master busy too long.
    task automatic start_txn(input int mode, input int blen, input int vat, input logic [7:0] rbyte);
        exp_t e;
        int   w;
        bit   vhit;
        w = rr_winner(req_m, ptr_m);
        if (w < 0) begin
            $display("[TB] FAIL start_txn no requester pending actual=0 required=1");
            errors++;
            w = 0;
        end
        e.w    = w;
        e.addr = addr_m[w];
        e.wd   = wd_m[w];
        if (!e.addr[0]) vat = 0;
        e.err  = (mode != 0);
        vhit   = (vat > 0) && (((mode == 0) && (vat <= blen)) || ((mode == 2) && (vat <= TO + 1)));
        if (vhit) last_rdata = rbyte;
        e.rvalid = e.addr[0] && vhit && (mode == 0);
        e.rdata  = last_rdata;
        e.lat    = (mode == 0) ? blen + 1 : ((mode == 1) ? TO + 1 : TO + 2);
        m_mode  = mode;
        m_blen  = blen;
        m_vat   = vat;
        m_rbyte = rbyte;
        sb.push_back(e);
        ptr_m = (w + 1) % N;
        cur_w = w;
    endtask

    // Wait for the completion pulse, then retire or refresh the served requester.
    task automatic finish_txn(input bit keep);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((o_done == '0) && (n < 300));
        if (o_done == '0) begin
            errors++;
            checks++;
            $display("[TB] FAIL done_wait actual=no_done required=done_within_300");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "[TB] completion never arrived");
        end
        if (keep) begin
            addr_m[cur_w] = 8'($urandom);
            wd_m[cur_w]   = 8'($urandom);
        end else begin
            req_m[cur_w] = 1'b0;
        end
        apply_stimulus();
    endtask

    // Behavioural I2C master: on a start pulse, hold busy for blen cycles and
    // optionally strobe read data on cycle vat (vat == blen coincides with busy fall).
    initial begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!manual && rst_n && o_m_req_trans) begin
                int         md;
                int         bl;
                int         va;
                logic [7:0] rb;
                md = m_mode;
                bl = m_blen;
                va = m_vat;
                rb = m_rbyte;
                if (md != 1) begin
                    m_busy  = 1'b1;
                    m_valid = 1'b0;
                    for (int k = 1; k <= bl; k++) begin
                        @(negedge clk);
                        if (k == bl) m_busy = 1'b0;
                        if (k == va) begin
                            m_valid = 1'b1;
                            m_rdata = rb;
                        end else begin
                            m_valid = 1'b0;
                        end
                    end
                    @(negedge clk);
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: check start pulses and completions against the scoreboard.
    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (o_m_req_trans) begin
                    if ((sb.size() == 0) || front_issued) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL req_trans actual=unexpected_pulse required=none");
                    end else begin
                        check_output("m_address", o_m_address, sb[0].addr);
                        check_output("m_write_data", o_m_write_data, sb[0].wd);
                        check_output("gnt_at_issue", o_gnt, 32'(1) << sb[0].w);
                        t_issue      = cyc;
                        front_issued = 1'b1;
                    end
                end
                if (o_done != '0) begin
                    if ((sb.size() == 0) || !front_issued) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL done actual=0x%0h required=no_pulse", o_done);
                    end else begin
                        e = sb.pop_front();
                        front_issued = 1'b0;
                        check_output("done_vec", o_done, 32'(1) << e.w);
                        check_output("gnt_at_done", o_gnt, 32'(1) << e.w);
                        check_output("err", o_err, e.err);
                        check_output("rvalid", o_rvalid, e.rvalid);
                        check_output("rdata", o_rdata, e.rdata);
                        check_output("done_latency", cyc - t_issue, e.lat);
                        idx = -1;
                        for (int k = 0; k < N; k++) if (o_done[k]) idx = k;
                        served.push_back(idx);
                    end
                end else if (o_err || o_rvalid) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stray_pulse actual=err%0b_rvalid%0b required=0", o_err, o_rvalid);
                end
            end
        end
    end

    // Global bound on run time.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int exp_order[5];
        int n;
        int r;
        int mode;
        int blen;
        int vat;
        exp_order = '{0, 1, 2, 3, 0};
        req_m = '0;
        for (int k = 0; k < N; k++) begin
            addr_m[k] = 8'h00;
            wd_m[k]   = 8'h00;
        end
        apply_stimulus();

        // Reset values.
        @(negedge clk);
        check_output("rst_gnt", o_gnt, 0);
        check_output("rst_done", o_done, 0);
        check_output("rst_req_trans", o_m_req_trans, 0);
        check_output("rst_address", o_m_address, 0);
        check_output("rst_rdata", o_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness with all four requesting continuously.
        for (int k = 0; k < N; k++) begin
            addr_m[k] = 8'($urandom);
            wd_m[k]   = 8'($urandom);
        end
        req_m = 4'hF;
        apply_stimulus();
        for (int i = 0; i < 5; i++) begin
            start_txn(0, 3 + int'($urandom % 5), int'($urandom % 3), 8'($urandom));
            finish_txn(1'b1);
        end
        req_m = '0;
        apply_stimulus();
        repeat (2) @(negedge clk);
        check_output("rr_count", served.size(), 5);
        if (served.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_output($sformatf("rr_order_%0d", i), served[i], exp_order[i]);
        end

        // Single write with request-to-grant and request-to-start timing.
        addr_m[0] = 8'h50;
        wd_m[0]   = 8'hA5;
        req_m     = 4'b0001;
        apply_stimulus();
        start_txn(0, 12, 0, 8'h00);
        @(negedge clk);
        check_output("gnt_t1", o_gnt, 4'b0001);
        check_output("req_trans_t1", o_m_req_trans, 0);
        @(negedge clk);
        check_output("req_trans_t2", o_m_req_trans, 1);
        finish_txn(1'b0);

        // Read from requester 2, data strobed as busy falls.
        addr_m[2] = 8'h91;
        wd_m[2]   = 8'h00;
        req_m     = 4'b0100;
        apply_stimulus();
        start_txn(0, 6, 6, 8'h3C);
        finish_txn(1'b0);

        // Master never goes busy, then a normal request is served.
        addr_m[1] = 8'h62;
        wd_m[1]   = 8'h11;
        req_m     = 4'b0010;
        apply_stimulus();
        start_txn(1, 0, 0, 8'h00);
        finish_txn(1'b0);
        addr_m[3] = 8'hA1;
        req_m     = 4'b1000;
        apply_stimulus();
        start_txn(0, 5, 2, 8'h77);
        finish_txn(1'b0);

        // Master stays busy past the limit after delivering a byte.
        addr_m[0] = 8'h43;
        req_m     = 4'b0001;
        apply_stimulus();
        start_txn(2, 25, 4, 8'hE7);
        finish_txn(1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_m[k] && ($urandom % 2 == 0)) begin
                    req_m[k]  = 1'b1;
                    addr_m[k] = 8'($urandom);
                    wd_m[k]   = 8'($urandom);
                end
            end
            if (req_m == '0) begin
                n = int'($urandom % N);
                req_m[n]  = 1'b1;
                addr_m[n] = 8'($urandom);
                wd_m[n]   = 8'($urandom);
            end
            apply_stimulus();
            r    = int'($urandom % 8);
            mode = (r < 6) ? 0 : ((r == 6) ? 1 : 2);
            blen = (mode == 2) ? 25 : 1 + int'($urandom % 12);
            vat  = (mode == 0) ? int'($urandom % (blen + 1)) : ((mode == 2) ? int'($urandom % 17) : 0);
            start_txn(mode, blen, vat, 8'($urandom));
            finish_txn($urandom % 4 == 0);
        end
        req_m = '0;
        apply_stimulus();
        repeat (30) @(negedge clk);

        // Asynchronous reset while the master is busy.
        manual    = 1'b1;
        addr_m[0] = 8'h21;
        wd_m[0]   = 8'h5A;
        req_m     = 4'b0001;
        apply_stimulus();
        start_txn(0, 10, 0, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_m_req_trans && (n < 20));
        check_output("manual_req_trans", o_m_req_trans, 1);
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_gnt", o_gnt, 0);
        check_output("arst_done", o_done, 0);
        check_output("arst_err", o_err, 0);
        check_output("arst_rdata", o_rdata, 0);
        check_output("arst_rvalid", o_rvalid, 0);
        check_output("arst_address", o_m_address, 0);
        check_output("arst_write_data", o_m_write_data, 0);
        check_output("arst_req_trans", o_m_req_trans, 0);
        sb.delete();
        front_issued = 1'b0;
        ptr_m        = 0;
        last_rdata   = 8'h00;
        @(negedge clk);
        addr_m[0] = 8'h33;
        wd_m[0]   = 8'h01;
        for (int k = 1; k < N; k++) begin
            addr_m[k] = 8'($urandom);
            wd_m[k]   = 8'($urandom);
        end
        req_m = 4'hF;
        apply_stimulus();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output($sformatf("no_gnt_while_busy_%0d", i), o_gnt, 0);
        end
        m_busy = 1'b0;
        manual = 1'b0;
        start_txn(0, 4, 2, 8'h99);
        finish_txn(1'b0);
        req_m = '0;
        apply_stimulus();
        repeat (3) @(negedge clk);
        check_output("post_reset_first_winner", served[served.size() - 1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master between `N_REQ` requesters. It sits between client blocks (sensor pollers, config loaders) and the I2C master. It latches the winning requester's address/data and issues a single `req_trans` pulse to the master. It then tracks the master's `busy`/`valid_out` handshake and returns completion, read data and timeout status to the granted requester.

## Interface
- `N_REQ`, 4: number of requesters, legal 2..8.
- `TIMEOUT_CYCLES`, 65535: max cycles allowed in each wait state before abort. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `i_sys_clk` in 1: system clock, all logic on rising edge.
- `i_sys_rstn` in 1: reset, asynchronous, active-low.
- `i_req` in N_REQ: per-requester level request. Held high until that requester's `o_done`.
- `i_addr` in N_REQ*8: requester k owns bits [8k+7:8k]. Bit 0 is R/W (1 = read).
- `i_wdata` in N_REQ*8: write data, same packing.
- `o_gnt` out N_REQ: one-hot grant, held for the whole transaction.
- `o_done` out N_REQ: one-cycle completion pulse to the granted requester.
- `o_err` out 1: one-cycle pulse coincident with `o_done` when the transaction timed out.
- `o_rdata` out 8: last read byte, holds until the next read completes.
- `o_rvalid` out 1: one-cycle pulse with `o_done` on a successful read.
- `o_m_address` out 8: to master `i_address`.
- `o_m_write_data` out 8: to master `i_write_data`.
- `o_m_req_trans` out 1: one-cycle start pulse to master.
- `i_m_busy` in 1: master busy.
- `i_m_read_data` in 8: master read data.
- `i_m_valid_out` in 1: master read-data strobe.

## Operation
- **States:** IDLE, ISSUE, WAIT_START, RUN, DONE.
- **IDLE**
  - If `i_req != 0` and `i_m_busy == 0`: select the winner by round-robin starting at pointer `ptr`.
  - Latch the winner's addr/wdata into `o_m_address`/`o_m_write_data`.
  - Set `o_gnt[w]`, then go to ISSUE.
  - If `i_m_busy == 1`, stay in IDLE. This covers a master still active after a reset.
- **ISSUE:** assert `o_m_req_trans` for exactly one cycle, clear the timeout counter, go to WAIT_START.
- **WAIT_START**
  - `i_m_busy == 1` → RUN, counter cleared.
  - Otherwise increment the counter. When it reaches `TIMEOUT_CYCLES`, set the abort flag and go to DONE.
- **RUN**
  - When `i_m_valid_out == 1`: capture `i_m_read_data` into `o_rdata` and set the read-seen flag.
  - `i_m_busy == 0` → DONE.
  - Counter increments every cycle. Reaching `TIMEOUT_CYCLES` → abort flag set, go to DONE.
  - If `valid_out` and busy-fall occur in the same cycle, data is still captured.
- **DONE**
  - Pulse `o_done[w]`.
  - `o_err` = abort flag.
  - `o_rvalid` = (addr bit0 && read-seen && !abort).
  - Clear `o_gnt`, set `ptr = (w+1) mod N_REQ`, clear flags, go to IDLE.
- **Round-robin:** the requester just served has the lowest priority next time. A requester that keeps `i_req` high after `o_done` is re-arbitrated normally.
- `i_addr`/`i_wdata`/`i_req` changes after grant are ignored until IDLE.
- Write transactions never pulse `o_rvalid`. `o_rdata` is unchanged on writes and on aborted reads without `valid_out`.

## Timing
- **Reset values:** state IDLE, `ptr` 0, and all outputs 0, including `o_gnt`, `o_done`, `o_err`, `o_rdata`, `o_rvalid`, `o_m_address`, `o_m_write_data`, `o_m_req_trans` and the counter.
- **Reset mid-transaction:** everything returns to reset values immediately. No `o_done` is issued for the lost transaction.
- **Request to grant:** `o_gnt` is registered in cycle T+1 after `i_req` is sampled high in IDLE at edge T. `o_m_req_trans` is high at T+2.
- **Master busy to done:** master `busy` falling at edge B gives `o_done` at B+1, and IDLE at B+2.
- **Back-to-back:** the minimum gap between consecutive `o_m_req_trans` pulses is the master busy time plus 4 cycles.
- **Timeout:** abort occurs exactly `TIMEOUT_CYCLES` cycles after entering WAIT_START or RUN, then `o_done`+`o_err` follow one cycle later.

## Test plan
- **Single write:** `i_req`=0001, addr0=0x50, wdata0=0xA5; master busy 20 cycles. Required:
  - `o_m_address`=0x50, `o_m_write_data`=0xA5.
  - One `o_m_req_trans` pulse 2 cycles after the request.
  - `o_done`=0001 one cycle after busy falls; `o_rvalid`=0, `o_err`=0.
- **Read:** requester 2, addr=0x91, master strobes `valid_out` with 0x3C. Required: `o_rdata`=0x3C, `o_rvalid`=1 and `o_done`=0100 in the same cycle.
- **Fairness:** `i_req`=1111 held continuously. Required: grant order is 0,1,2,3,0, with no requester served twice before all others.
- **Timeout:** `TIMEOUT_CYCLES`=16, master never asserts busy. Required: `o_done`+`o_err` exactly 17 cycles after `o_m_req_trans`, and the next request is served normally.
- **Async reset during RUN:** assert reset mid-transaction with master busy still high. Required:
  - All outputs 0 immediately.
  - After release, no grant until busy falls.
  - Then the pending request is granted to requester 0 first.
